// File: rtl/ifetch_ctrl_if.sv
// Fetch-side bus bundle: instruction ROM port, decode handshake and redirect.
// master = fetch sequencer, slave = the ROM/decode/branch environment.
interface ifetch_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output mem_addr, out_valid, out_pc, out_instr,
    input  mem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  mem_addr, out_valid, out_pc, out_instr,
    output mem_rdata, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ifetch_ctrl.sv
// miniRV fetch sequencer: owns fetch_pc, reads the combinational ROM, buffers
// {pc, instr} pairs in a DEPTH-entry prefetch FIFO toward decode, and handles
// redirects, halts and out-of-range fetch faults.
// Optional perf counters are built only when IFETCH_PERF_EN is defined.
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IMEM_BYTES = 32'h0400_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  ifetch_ctrl_if.master bus,
  input  logic        halt_req,
  output logic        halted,
  output logic        fetch_fault,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stall
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {BOOT, RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] count, count_next;
  logic [PW-1:0] head, tail;
  entry_t        fifo_q [DEPTH];

  logic        valid, pop, space, fetch_ok, in_range, push, fault_set;
  logic [31:0] target;

  assign valid  = (count != '0);
  assign target = bus.redirect_pc & ~32'h3;

  // Push/pop decisions; a redirect voids both and empties the FIFO.
  always_comb begin
    pop        = valid && bus.out_ready && !bus.redirect_valid;
    space      = (count < DEPTH_C) || pop;
    fetch_ok   = (state == RUN) && !halt_req && !fetch_fault && !bus.redirect_valid;
    in_range   = (fetch_pc < IMEM_BYTES);
    push       = fetch_ok && space && in_range;
    fault_set  = fetch_ok && space && !in_range;
    count_next = count;
    if (bus.redirect_valid) count_next = '0;
    else if (push && !pop)  count_next = count + CW'(1);
    else if (!push && pop)  count_next = count - CW'(1);
  end

  // Control FSM, fetch PC, FIFO pointers and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= BOOT;
      halted      <= 1'b0;
      fetch_pc    <= RESET_PC & ~32'h3;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      fetch_fault <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state  <= RUN;
          halted <= 1'b0;
        end
        RUN: begin
          if (halt_req && count_next == '0) begin
            state  <= HALTED;
            halted <= 1'b1;
          end
        end
        HALTED: begin
          // A redirect while halted only retargets; resume waits for halt_req=0.
          if (!bus.redirect_valid && !halt_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= BOOT;
          halted <= 1'b0;
        end
      endcase

      count <= count_next;
      if (bus.redirect_valid) begin
        head        <= '0;
        tail        <= '0;
        fetch_pc    <= target;
        fetch_fault <= 1'b0;
      end else begin
        if (push) begin
          tail     <= tail + 1'b1;
          fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop)       head        <= head + 1'b1;
        if (fault_set) fetch_fault <= 1'b1;
      end
    end
  end

  // FIFO storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail] <= '{pc: fetch_pc, instr: bus.mem_rdata};
  end

  assign bus.mem_addr  = fetch_pc;
  assign bus.out_valid = valid;
  assign bus.out_pc    = fifo_q[head].pc;
  assign bus.out_instr = fifo_q[head].instr;

`ifdef IFETCH_PERF_EN
  logic stall;
  // A stall is a RUN cycle that would have fetched but for a full FIFO.
  assign stall = fetch_ok && !space && in_range;

  // Free-running perf counters, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push)  perf_fetched <= perf_fetched + 32'd1;
      if (stall) perf_stall   <= perf_stall + 32'd1;
    end
  end
`else
  assign perf_fetched = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Fetch sequencer for the miniRV core. It owns the fetch PC and drives the address of the combinational instruction ROM (word index = pc[25:2]). It captures {pc, instruction} pairs into a small prefetch FIFO and presents them to decode over a valid/ready handshake. It also handles branch/jump redirects, halt requests and out-of-range fetch faults.

Parameters:
RESET_PC, 32'h0000_0000, fetch address loaded at reset; bits [1:0] forced to 0.
IMEM_BYTES, 32'h0400_0000, ROM size in bytes (16,777,216 words); a fetch at pc >= IMEM_BYTES is a fault.
DEPTH, 2, prefetch FIFO entries; legal values 2 or 4.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
mem_addr  out  32  address to instruction ROM; equals fetch_pc.
mem_rdata  in  32  combinational ROM data for mem_addr, valid in the same cycle.
out_valid  out  1  FIFO head holds a valid entry.
out_ready  in  1  decode accepts the head entry this cycle.
out_pc  out  32  PC of the head entry.
out_instr  out  32  instruction of the head entry.
redirect_valid  in  1  one-cycle pulse; flush the FIFO and refetch from redirect_pc.
redirect_pc  in  32  new fetch target; bits [1:0] ignored (treated as 0).
halt_req  in  1  level; stop fetching and drain the FIFO.
halted  out  1  state is HALTED.
fetch_fault  out  1  sticky flag: fetch_pc is out of range.
perf_fetched  out  32  perf counter (see Optional Feature).
perf_stall  out  32  perf counter (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - fetch_pc=RESET_PC, FIFO count=0, state=BOOT.
  - out_valid=0, halted=0, fetch_fault=0, perf counters=0.
  - Reset mid-operation discards all FIFO contents.
- States and transitions:
  - BOOT -> RUN after one cycle. No fetch occurs in BOOT.
  - RUN -> HALTED when halt_req=1 and the FIFO is empty after this cycle's pop.
  - HALTED -> RUN in the cycle after halt_req=0.
- Push rule: push in a cycle when state=RUN, halt_req=0, fetch_fault=0, redirect_valid=0, and the FIFO has space.
  - Space means count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - On push: write {fetch_pc, mem_rdata} at the tail and set fetch_pc <= fetch_pc+4.
  - The add is 32-bit modulo: 0xFFFF_FFFC wraps to 0x0000_0000.
- Pop rule: pop when out_valid && out_ready.
  - Head outputs are stable while out_valid=1 and out_ready=0.
  - Simultaneous push and pop leaves count unchanged.
- Redirect has the highest priority over push, pop and halt:
  - count <= 0 and fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - fetch_fault is cleared.
  - Any pop in that cycle is void; decode must not treat the head as consumed.
- Redirect latency:
  - Pulse in cycle t; out_valid=0 in t+1.
  - out_valid=1 with out_pc=target in t+2, provided RUN and no halt.
- Redirect while HALTED: loads fetch_pc and stays HALTED.
- Redirect during BOOT: loads fetch_pc; BOOT still proceeds to RUN.
- halt_req: push is suppressed immediately; already-fetched entries still drain to decode.
- Fault:
  - If fetch_pc >= IMEM_BYTES when a push would otherwise occur, set fetch_fault=1 and do not push.
  - The flag holds until redirect or reset; buffered entries still drain.
- mem_addr is the registered fetch_pc; there are no combinational paths from inputs to mem_addr.

Optional Feature:
Macro IFETCH_PERF_EN.
- Defined:
  - perf_fetched increments on every push.
  - perf_stall increments on every RUN cycle where a push is blocked only by a full FIFO.
  - Both counters are 32-bit, wrap at 2^32, and clear on reset only.
- Undefined: both outputs are tied to 32'h0 and no counter flops are generated.

Test Plan:
- Reset release with RESET_PC=0, ROM[i]=i, out_ready=1 -> first out_valid in cycle 2 after reset with out_pc=0, out_instr=0; then pc 4, 8, 12 on consecutive cycles.
- out_ready=0 for 6 cycles, DEPTH=2 -> FIFO holds pc 0 and 4, mem_addr stays 8, head stable; perf_stall=4 with IFETCH_PERF_EN defined, 0 without.
- redirect_valid pulse with redirect_pc=0x103 while FIFO is full -> out_valid=0 next cycle; two cycles after the pulse out_pc=0x100, out_instr=ROM[0x40]; the stale entries are never presented.
- halt_req=1 with 2 entries buffered, out_ready=1 -> both entries drain, halted=1 on the following cycle, mem_addr frozen; deassert -> fetch resumes at the frozen PC.
- redirect_pc=0x03FF_FFFC -> one entry fetched, then fetch_fault=1 with no further pushes; redirect to 0x0 -> fault clears and fetch resumes at 0.
- redirect_pc=0xFFFF_FFFC with IMEM_BYTES=32'hFFFF_FFFF -> next fetched pc is 0x0000_0000 (wrap).
